// File: rtl/tetris_pkg.sv
// Shared definitions for the board lock/line-clear block.
//   ROWS, COLS    default board geometry (row 0 bottom, row ROWS-1 top)
//   FULL_ROW      all-ones row pattern for the default width
//   row_t         one board row
//   lock_state_t  lock controller states
package tetris_pkg;

    localparam int ROWS = 22;
    localparam int COLS = 10;

    typedef logic [COLS-1:0] row_t;

    localparam row_t FULL_ROW = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } lock_state_t;

endpackage

// File: rtl/board_shift.sv
// Combinational row removal: drops row r and moves every row above it down
// by one, feeding an empty row in at the top.
//   board    [ROWS-1:0][COLS-1:0]  current grid
//   r        [RW-1:0]              row to remove
//   shifted  [ROWS-1:0][COLS-1:0]  grid with row r removed
module board_shift #(
    parameter int ROWS = 22,
    parameter int COLS = 10,
    parameter int RW   = $clog2(ROWS)
) (
    input  logic [ROWS-1:0][COLS-1:0] board,
    input  logic [RW-1:0]             r,
    output logic [ROWS-1:0][COLS-1:0] shifted
);

    always_comb begin
        shifted = board;
        for (int j = 0; j < ROWS-1; j++) begin
            if (j >= int'(r)) begin
                shifted[j] = board[j+1];
            end
        end
        // Top row always empties; r never exceeds ROWS-1.
        shifted[ROWS-1] = '0;
    end

endmodule

// File: rtl/board_lock.sv
// Merges a falling piece into the locked board, then removes full rows one
// scan step per cycle, reporting per-lock and running line counts.
//   Clk            clock
//   Reset_h        synchronous active-high reset
//   active         falling-piece grid, sampled only while merging
//   lock           request to merge active into the board
//   clear_board    zero the board (IDLE only, lock wins)
//   board          registered locked-cell grid
//   busy           high outside IDLE
//   done           one-cycle pulse while in DONE
//   lines_cleared  rows removed by the last lock (saturates at 7)
//   lines_total    running count of cleared rows, wraps
//   game_over      sticky: cells left in the top two rows after a lock
//
// state | meaning
// IDLE  | waiting for lock; clear_board honoured here
// MERGE | OR piece into board, reset scan row and per-lock count
// SCAN  | inspect row r; full -> shift down and re-inspect, else r+1
// DONE  | publish counts, update game_over, back to IDLE
module board_lock #(
    parameter int ROWS = tetris_pkg::ROWS,
    parameter int COLS = tetris_pkg::COLS
) (
    input  logic                      Clk,
    input  logic                      Reset_h,
    input  logic [ROWS-1:0][COLS-1:0] active,
    input  logic                      lock,
    input  logic                      clear_board,
    output logic [ROWS-1:0][COLS-1:0] board,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                lines_cleared,
    output logic [15:0]               lines_total,
    output logic                      game_over
);

    import tetris_pkg::*;

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0]   TOP_ROW = RW'(ROWS-1);
    localparam logic [COLS-1:0] ALL_ONES = '1;

    lock_state_t               state_q, state_d;
    logic [ROWS-1:0][COLS-1:0] board_q, board_d;
    logic [RW-1:0]             r_q, r_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                lines_cleared_q, lines_cleared_d;
    logic [15:0]               lines_total_q, lines_total_d;
    logic                      game_over_q, game_over_d;
    logic [ROWS-1:0][COLS-1:0] shifted;

    board_shift #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW)
    ) u_shift (
        .board   (board_q),
        .r       (r_q),
        .shifted (shifted)
    );

    always_comb begin
        state_d         = state_q;
        board_d         = board_q;
        r_d             = r_q;
        cnt_d           = cnt_q;
        lines_cleared_d = lines_cleared_q;
        lines_total_d   = lines_total_q;
        game_over_d     = game_over_q;

        case (state_q)
            IDLE: begin
                if (lock) begin
                    state_d = MERGE;
                end else if (clear_board) begin
                    board_d = '0;
                end
            end
            MERGE: begin
                board_d = board_q | active;
                r_d     = '0;
                cnt_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (board_q[r_q] == ALL_ONES) begin
                    // Row r is refilled from above, so r is inspected again.
                    board_d = shifted;
                    if (cnt_q != 3'd7) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (r_q == TOP_ROW) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            DONE: begin
                lines_cleared_d = cnt_q;
                lines_total_d   = lines_total_q + 16'(cnt_q);
                if ((|board_q[ROWS-1]) || (|board_q[ROWS-2])) begin
                    game_over_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q         <= IDLE;
            board_q         <= '0;
            r_q             <= '0;
            cnt_q           <= '0;
            lines_cleared_q <= '0;
            lines_total_q   <= '0;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            board_q         <= board_d;
            r_q             <= r_d;
            cnt_q           <= cnt_d;
            lines_cleared_q <= lines_cleared_d;
            lines_total_q   <= lines_total_d;
            game_over_q     <= game_over_d;
        end
    end

    assign board         = board_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign lines_cleared = lines_cleared_q;
    assign lines_total   = lines_total_q;
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_board_lock.sv
module tb_board_lock;

    localparam int ROWS = 22;
    localparam int COLS = 10;
    localparam logic [COLS-1:0] FULLR = '1;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef struct {
        logic            clr;
        board_t          act;
        logic [2:0]      exp_k;
        logic [COLS-1:0] exp_row0;
        logic            exp_go;
    } vec_t;

    typedef struct {
        board_t      brd;
        logic [2:0]  k;
        logic [15:0] total;
        logic        go;
        int          lat;
    } exp_t;

    logic        clk;
    logic        Reset_h;
    board_t      active;
    logic        lock;
    logic        clear_board;
    board_t      board;
    logic        busy;
    logic        done;
    logic [2:0]  lines_cleared;
    logic [15:0] lines_total;
    logic        game_over;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t   sb_q[$];
    board_t m_board;
    logic [15:0] m_total;
    logic   m_go;

    board_lock #(.ROWS(ROWS), .COLS(COLS)) dut (
        .Clk           (clk),
        .Reset_h       (Reset_h),
        .active        (active),
        .lock          (lock),
        .clear_board   (clear_board),
        .board         (board),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .lines_total   (lines_total),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic check_board(input string name, input board_t exp);
        n_checks++;
        if (board !== exp) $display("FAIL %s: board got %h expected %h", name, board, exp);
        else n_pass++;
    endtask

    // Reference: merge, then keep the non-full rows compacted downward.
    function automatic exp_t model_lock(input board_t act);
        exp_t   e;
        board_t mg;
        int     idx;
        int     k;
        mg    = m_board | act;
        e.brd = '0;
        idx   = 0;
        k     = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (mg[i] == FULLR) k++;
            else begin
                e.brd[idx] = mg[i];
                idx++;
            end
        end
        e.k     = (k > 7) ? 3'd7 : 3'(k);
        e.total = m_total + 16'(e.k);
        e.go    = m_go | (|e.brd[ROWS-1]) | (|e.brd[ROWS-2]);
        e.lat   = 2 + ROWS + k;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        Reset_h = 1'b1;
        @(posedge clk);
        #1;
        Reset_h = 1'b0;
        m_board = '0;
        m_total = '0;
        m_go    = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_board = 1'b1;
        @(posedge clk);
        #1;
        clear_board = 1'b0;
        m_board = '0;
        check_board("clear_board", m_board);
    endtask

    // disturb: mid-SCAN, re-request lock with a different active grid.
    task automatic run_lock(input board_t act, input logic with_clr, input logic disturb);
        exp_t e;
        exp_t got_e;
        int   cyc;
        bit   seen;
        e = model_lock(act);
        sb_q.push_back(e);
        m_board = e.brd;
        m_total = e.total;
        m_go    = e.go;

        @(negedge clk);
        active      = act;
        lock        = 1'b1;
        clear_board = with_clr;
        @(posedge clk);
        #1;
        lock        = 1'b0;
        clear_board = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            lock = 1'b0;
            if (cyc == 1) check("busy_in_scan", busy, 1);
            if (disturb && cyc == 5) begin
                lock   = 1'b1;
                active = '1;
            end
            if (done) seen = 1;
        end
        got_e = sb_q.pop_front();
        if (!seen) begin
            n_checks++;
            $display("FAIL lock_timeout: no done after %0d cycles, expected done at %0d", cyc, got_e.lat);
        end else begin
            check("latency", cyc + 1, got_e.lat);
            check_board("board_at_done", got_e.brd);
            @(posedge clk);
            #1;
            active = '0;
            check("done_one_cycle", done, 0);
            check("busy_idle", busy, 0);
            check("lines_cleared", lines_cleared, got_e.k);
            check("lines_total", lines_total, got_e.total);
            check("game_over", game_over, got_e.go);
        end
    endtask

    initial begin
        vec_t   vecs[8];
        board_t b;
        int     dones;

        b = '0; b[0] = 10'h00F; b[1] = 10'h00F;
        vecs[0] = '{1'b0, b, 3'd0, 10'h00F, 1'b0};
        b = '0; b[0] = 10'h3F0;
        vecs[1] = '{1'b1, b, 3'd0, 10'h3F0, 1'b0};
        b = '0; b[0] = 10'h00F;
        vecs[2] = '{1'b0, b, 3'd1, 10'h000, 1'b0};
        b = '0; for (int i = 0; i < 4; i++) b[i] = 10'h3FE;
        vecs[3] = '{1'b1, b, 3'd0, 10'h3FE, 1'b0};
        b = '0; for (int i = 0; i < 4; i++) b[i] = 10'h001;
        vecs[4] = '{1'b0, b, 3'd4, 10'h000, 1'b0};
        b = '0; b[0] = 10'h3F0; b[1] = 10'h001; b[2] = 10'h3F0;
        vecs[5] = '{1'b1, b, 3'd0, 10'h3F0, 1'b0};
        b = '0; b[0] = 10'h00F; b[2] = 10'h00F;
        vecs[6] = '{1'b0, b, 3'd2, 10'h001, 1'b0};
        b = '0; b[20] = 10'h001; b[21] = 10'h001;
        vecs[7] = '{1'b1, b, 3'd0, 10'h000, 1'b1};

        Reset_h     = 1'b1;
        active      = '0;
        lock        = 1'b0;
        clear_board = 1'b0;
        m_board     = '0;
        m_total     = '0;
        m_go        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset_h = 1'b0;

        check_board("rst_board", '0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lines_cleared", lines_cleared, 0);
        check("rst_lines_total", lines_total, 0);
        check("rst_game_over", game_over, 0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].clr) do_clear();
            run_lock(vecs[v].act, 1'b0, 1'b0);
            check($sformatf("vec%0d_k", v), lines_cleared, vecs[v].exp_k);
            check($sformatf("vec%0d_row0", v), board[0], vecs[v].exp_row0);
            check($sformatf("vec%0d_go", v), game_over, vecs[v].exp_go);
        end

        // game_over and lines_total survive clear_board; only reset clears them.
        do_clear();
        check("go_after_clear", game_over, 1);
        check("total_after_clear", lines_total, 7);
        do_reset();
        check("go_after_reset", game_over, 0);
        check("total_after_reset", lines_total, 0);
        check_board("board_after_reset", '0);

        // Full top row shifts zeros in and finishes a cycle later.
        b = '0; b[ROWS-1] = 10'h3FF;
        run_lock(b, 1'b0, 1'b0);

        // lock together with clear_board: lock wins, prior cells kept.
        b = '0; b[3] = 10'h0AA;
        run_lock(b, 1'b0, 1'b0);
        b = '0; b[5] = 10'h155;
        run_lock(b, 1'b1, 1'b0);
        check("lock_beats_clear_row3", board[3], 10'h0AA);

        // A second lock mid-SCAN (with a changed active grid) is dropped.
        b = '0; b[6] = 10'h0F0;
        run_lock(b, 1'b0, 1'b1);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("no_queued_lock", dones, 0);
        check_board("board_after_ignored_lock", m_board);

        // Every row full: per-lock count saturates at 7.
        run_lock('1, 1'b0, 1'b0);

        // Reset five cycles into SCAN aborts the lock without a done pulse.
        b = '0; b[0] = 10'h00F;
        @(negedge clk);
        active = b;
        lock   = 1'b1;
        @(posedge clk);
        #1;
        lock = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        Reset_h = 1'b1;
        @(posedge clk);
        #1;
        Reset_h = 1'b0;
        active  = '0;
        m_board = '0;
        m_total = '0;
        m_go    = 1'b0;
        check_board("midscan_reset_board", '0);
        check("midscan_reset_busy", busy, 0);
        check("midscan_reset_total", lines_total, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("midscan_no_done", dones, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/board_lock.md
BOARD_LOCK -- requirements
Module: board_lock

Interface
REQ-001 SHALL have parameter ROWS, default 22, meaning board height in rows (row 0 bottom, row ROWS-1 top).
REQ-002 SHALL have parameter COLS, default 10, meaning board width in cells.
REQ-003 SHALL have port Clk  input  1  sole clock; all state changes on posedge Clk.
REQ-004 SHALL have port Reset_h  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port active  input  [COLS-1:0] x ROWS  falling-piece grid from write_mux (next_write).
REQ-006 SHALL have port lock  input  1  single-cycle request to merge active into the board.
REQ-007 SHALL have port clear_board  input  1  request to zero the board; honoured only in IDLE.
REQ-008 SHALL have port board  output  [COLS-1:0] x ROWS  registered locked-cell grid.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  high for exactly one cycle, while in DONE.
REQ-011 SHALL have port lines_cleared  output  3  full rows removed by the last lock, 0..4 in legal play.
REQ-012 SHALL have port lines_total  output  16  running count of cleared rows, wraps modulo 2^16.
REQ-013 SHALL have port game_over  output  1  sticky flag; set when locked cells remain in rows ROWS-2..ROWS-1 after a clear.

Function
REQ-014 SHALL implement states IDLE, MERGE, SCAN, DONE, with busy and done as Moore outputs.
REQ-015 IDLE: lock=1 SHALL move to MERGE; otherwise, clear_board=1 SHALL zero board and stay in IDLE.
REQ-016 IDLE: lock and clear_board high together SHALL take lock; clear_board is ignored.
REQ-017 lock asserted while busy SHALL be ignored, with no queuing.
REQ-018 MERGE (one cycle) SHALL set board[i] = board[i] | active[i] for all rows, set scan row r=0, clear the per-lock line count, then enter SCAN.
REQ-019 SCAN SHALL inspect one row per cycle.
REQ-020 SCAN, board[r]==all-ones: SHALL set board[j]=board[j+1] for r<=j<ROWS-1, set board[ROWS-1]=0, increment the line count, keep r unchanged and re-inspect r next cycle.
REQ-021 SCAN, board[r] not full and r<ROWS-1: SHALL set r=r+1.
REQ-022 SCAN, board[ROWS-1] not full: SHALL go to DONE.
REQ-023 SCAN, full top row: SHALL shift in zeros, then finish on the next cycle.
REQ-024 Latency: done SHALL be high 2+ROWS+k cycles after the edge sampling lock, where k is the number of rows cleared (24 for k=0).
REQ-025 DONE SHALL drive lines_cleared with k and add k to lines_total.
REQ-026 DONE SHALL set game_over if any bit of board[ROWS-1] or board[ROWS-2] is set, then return to IDLE.
REQ-027 lines_cleared SHALL hold its value until the next DONE.
REQ-028 The per-lock counter SHALL saturate at 7.
REQ-029 board SHALL change only in MERGE, SCAN shifts, clear_board, or reset.
REQ-030 clear_board SHALL NOT clear game_over or lines_total.
REQ-031 active SHALL be sampled only in MERGE.

Reset
REQ-032 Reset_h SHALL set state=IDLE, board all zero, r=0, lines_cleared=0, lines_total=0, game_over=0, busy=0, done=0.
REQ-033 Reset_h SHALL take priority over every other input, including mid-SCAN; an interrupted lock SHALL produce no done pulse.

Structure
REQ-034 The shared package tetris_pkg SHALL hold ROWS, COLS, FULL_ROW (all-ones), the row-vector typedef, and the lock_state_t enum.
REQ-035 The combinational row shift-down at index r SHALL be a sub-module, board_shift (inputs board and r, output shifted board).
REQ-036 All state SHALL be in one sequential process; next-state and shift logic SHALL be combinational.

Verification
REQ-037 Empty board, active rows 0..1 = 10'h00F, lock -> done after 24 cycles; board[0]=board[1]=10'h00F; lines_cleared=0; game_over=0.
REQ-038 board[0]=10'h3F0 preloaded via lock, then active[0]=10'h00F, lock -> board[0]=0 and rows shifted; lines_cleared=1; lines_total=1; done at cycle 25.
REQ-039 Rows 0..3 each 10'h3FE, active I-piece column 0 rows 0..3, lock -> board all zero; lines_cleared=4; done at cycle 28.
REQ-040 Non-adjacent full rows 0 and 2, row 1=10'h001 -> board[0]=10'h001, rest 0; lines_cleared=2.
REQ-041 Piece locked into rows 20..21 with no clear -> game_over=1 at done; stays 1 after clear_board; 0 only after Reset_h.
REQ-042 Reset_h asserted 5 cycles into SCAN -> next cycle board=0, busy=0, done never pulses; a lock during busy is ignored (board unchanged).
